pc_fetch_unit: RTL

//  Program-counter register and instruction-fetch sequencer at the head of the datapath.

---
 rtl/mips_pkg.sv | 17 +
 rtl/pc_register.sv | 23 ++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: controller state encoding,
// instruction width and the default reset PC.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

endpackage : mips_pkg

// File: rtl/pc_register.sv
// Program-counter storage: NBits-wide register with load enable that
// returns to RESET_PC whenever reset is asserted.
module pc_register #(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBits-1:0] d,
  output logic [NBits-1:0] q
);

  // Load a new PC only when the controller accepts a retired instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pc_register

// File: rtl/pc_fetch_unit.sv
// PC register plus instruction-fetch sequencer. Issues one fetch per PC
// over a req/gnt handshake, captures the response, holds it valid until
// the core retires it, and halts permanently on a misaligned next PC.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = NBits'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NBits-1:0]   NextPC,
  input  logic               Advance,
  output logic               IMemReq,
  output logic [NBits-1:0]   IMemAddr,
  input  logic               IMemGnt,
  input  logic               IMemRspValid,
  input  logic [INSTR_W-1:0] IMemRdData,
  output logic [NBits-1:0]   PC,
  output logic [NBits-1:0]   PCPlus4,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic               AlignFault
);

  fetch_state_t state;
  fetch_state_t nextState;
  logic         retireOk;
  logic         retireBad;
  logic         captureRsp;

  // Qualify the retire and capture events by state so stray inputs are ignored.
  always_comb begin
    retireOk   = 1'b0;
    retireBad  = 1'b0;
    captureRsp = 1'b0;
    if (state == S_VALID && Advance) begin
      retireOk  = (NextPC[1:0] == 2'b00);
      retireBad = (NextPC[1:0] != 2'b00);
    end
    if (state == S_WAIT && IMemRspValid) begin
      captureRsp = 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic and state-decoded outputs; outputs never see inputs directly.
  always_comb begin
    nextState  = state;
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    unique case (state)
      S_IDLE: begin
        nextState = S_FETCH;
      end
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemGnt) begin
          nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMemRspValid) begin
          nextState = S_VALID;
        end
      end
      S_VALID: begin
        InstrValid = 1'b1;
        if (retireOk) begin
          nextState = S_FETCH;
        end else if (retireBad) begin
          nextState = S_HALT;
        end
      end
      S_HALT: begin
        InstrValid = 1'b1;
      end
      default: begin
        nextState = S_IDLE;
      end
    endcase
  end

  pc_register #(
    .NBits   (NBits),
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk  (clk),
    .reset(reset),
    .en   (retireOk),
    .d    (NextPC),
    .q    (PC)
  );

  // Capture the fetched word when the response arrives while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instruction <= '0;
    end else if (captureRsp) begin
      Instruction <= IMemRdData;
    end
  end

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AlignFault <= 1'b0;
    end else if (retireBad) begin
      AlignFault <= 1'b1;
    end
  end

  assign IMemAddr = PC;
  assign PCPlus4  = PC + NBits'(4);

endmodule : pc_fetch_unit
